// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared constants and queue entry type for the fetch stage
package inst_fetch_unit_pkg;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam int IF_QUEUE_DEPTH = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// inst_fetch_unit_fetch_fifo: flushable queue of fetched {pc, inst} pairs with zeroed head when empty
module inst_fetch_unit_fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = IF_QUEUE_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output logic [CW-1:0] count,
  output logic         valid,
  output fetch_entry_t head
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign valid = count != '0;
  assign head = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      assert (!push || pop || count < CW'(DEPTH));
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: IF stage issuing IROM fetches, buffering responses and handling redirects
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter int DEPTH = IF_QUEUE_DEPTH
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  logic [31:0] pc_q, inflight_pc, target;
  logic inflight, pop, push;
  logic [CW-1:0] count;
  logic [OW-1:0] occupancy;
  fetch_entry_t head, entry;
  assign target = {redirect_pc[31:2], 2'b00};
  assign pop = if_valid & if_ready & ~redirect_valid;
  assign push = inflight & ~redirect_valid;
  assign occupancy = OW'(count) + OW'(inflight) - OW'(pop);
  assign irom_req = ~cpu_rst & (redirect_valid | (occupancy < OW'(DEPTH)));
  assign irom_addr = redirect_valid ? target : pc_q;
  assign entry = '{pc: inflight_pc, inst: irom_rdata};
  assign if_pc = head.pc;
  assign if_inst = head.inst;
  assign if_pc4 = if_valid ? head.pc + 32'd4 : '0;
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc_q <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= irom_req;
      if (irom_req) begin
        inflight_pc <= irom_addr;
        pc_q <= irom_addr + 32'd4;
      end
    end
  end
  inst_fetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(cpu_clk),
    .rst(cpu_rst),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .wdata(entry),
    .count(count),
    .valid(if_valid),
    .head(head)
  );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed and randomised checks of the fetch stage against a queue-based model
module tb_inst_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam int DEPTH = 2;
  logic cpu_clk = 1'b0, cpu_rst = 1'b1, redirect_valid = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = '0, rom_q = '0;
  logic irom_req, if_valid;
  logic [31:0] irom_addr, irom_rdata, if_pc, if_pc4, if_inst;
  int total = 0, bad = 0;
  logic [31:0] mq[$];
  logic [31:0] mpc = '0, mfl_pc = '0;
  bit mfl = 1'b0;
  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk) rom_q <= irom_addr ^ K;
  assign irom_rdata = rom_q;
  inst_fetch_unit dut (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .irom_req(irom_req),
    .irom_addr(irom_addr),
    .irom_rdata(irom_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_pc(if_pc),
    .if_pc4(if_pc4),
    .if_inst(if_inst)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model();
    logic [31:0] hp, t;
    bit ev, pop, req;
    int occ;
    ev = mq.size() > 0;
    hp = ev ? mq[0] : 32'h0;
    chk("if_valid", 32'(if_valid), 32'(ev));
    chk("if_pc", if_pc, hp);
    chk("if_pc4", if_pc4, ev ? hp + 32'd4 : 32'h0);
    chk("if_inst", if_inst, ev ? hp ^ K : 32'h0);
    pop = ev && if_ready && !redirect_valid;
    occ = mq.size() + int'(mfl) - int'(pop);
    req = !cpu_rst && (redirect_valid || occ < DEPTH);
    t = redirect_valid ? (redirect_pc & ~32'h3) : mpc;
    chk("irom_req", 32'(irom_req), 32'(req));
    if (req) chk("irom_addr", irom_addr, t);
    if (cpu_rst) begin
      mq.delete();
      mfl = 1'b0;
      mpc = 32'h0;
    end else if (redirect_valid) begin
      mq.delete();
      mfl = 1'b1;
      mfl_pc = t;
      mpc = t + 32'd4;
    end else begin
      if (pop) void'(mq.pop_front());
      if (mfl) mq.push_back(mfl_pc);
      mfl = req;
      if (req) begin
        mfl_pc = mpc;
        mpc = mpc + 32'd4;
      end
    end
  endtask
  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    cpu_rst = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    if_ready = rdy;
    #1;
  endtask
  task automatic tick();
    @(negedge cpu_clk);
    model();
    @(posedge cpu_clk);
    #1;
  endtask
  initial begin
    drive(1, 0, 0, 1);
    tick(); tick(); tick();
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    drive(0, 0, 0, 1);
    chk("t0_req", 32'(irom_req), 32'h1);
    chk("t0_addr", irom_addr, 32'h0);
    chk("t0_valid", 32'(if_valid), 32'h0);
    tick();
    drive(0, 0, 0, 1);
    chk("t1_valid", 32'(if_valid), 32'h0);
    chk("t1_addr", irom_addr, 32'h4);
    tick();
    drive(0, 0, 0, 1);
    chk("t2_valid", 32'(if_valid), 32'h1);
    chk("t2_pc", if_pc, 32'h0);
    chk("t2_inst", if_inst, 32'hA5A5_0000);
    chk("t2_pc4", if_pc4, 32'h4);
    tick();
    chk("t3_pc", if_pc, 32'h4);
    tick();
    chk("t4_pc", if_pc, 32'h8);
    tick();
    chk("t5_pc", if_pc, 32'hC);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      chk("stall_pc", if_pc, 32'h10);
      chk("stall_req", 32'(irom_req), 32'h0);
      tick();
    end
    drive(0, 0, 0, 1);
    chk("resume_pc0", if_pc, 32'h10);
    chk("resume_addr", irom_addr, 32'h18);
    tick();
    chk("resume_pc1", if_pc, 32'h14);
    tick();
    chk("resume_pc2", if_pc, 32'h18);
    drive(0, 0, 0, 0);
    tick();
    drive(0, 1, 32'h0000_0203, 0);
    chk("redir_req", 32'(irom_req), 32'h1);
    chk("redir_addr", irom_addr, 32'h200);
    tick();
    drive(0, 0, 0, 1);
    chk("redir_gap", 32'(if_valid), 32'h0);
    tick();
    chk("redir_valid", 32'(if_valid), 32'h1);
    chk("redir_pc", if_pc, 32'h200);
    chk("redir_pc4", if_pc4, 32'h204);
    tick();
    drive(0, 1, 32'h40, 1);
    chk("race_head", if_pc, 32'h204);
    chk("race_addr", irom_addr, 32'h40);
    tick();
    drive(0, 0, 0, 1);
    chk("race_gap", 32'(if_valid), 32'h0);
    tick();
    chk("race_pc", if_pc, 32'h40);
    tick();
    drive(0, 1, 32'h100, 1);
    tick();
    drive(0, 1, 32'h300, 1);
    chk("b2b_addr", irom_addr, 32'h300);
    tick();
    drive(0, 0, 0, 1);
    chk("b2b_gap", 32'(if_valid), 32'h0);
    tick();
    chk("b2b_pc0", if_pc, 32'h300);
    tick();
    chk("b2b_pc1", if_pc, 32'h304);
    drive(0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1);
    chk("mrst_valid", 32'(if_valid), 32'h0);
    chk("mrst_pc", if_pc, 32'h0);
    chk("mrst_inst", if_inst, 32'h0);
    chk("mrst_addr", irom_addr, 32'h0);
    tick();
    tick();
    chk("mrst_pc0", if_pc, 32'h0);
    chk("mrst_inst0", if_inst, 32'hA5A5_0000);
    drive(0, 1, 32'hFFFF_FFFF, 1);
    chk("wrap_addr", irom_addr, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0, 1);
    tick();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc4, 32'h0);
    chk("wrap_inst", if_inst, 32'h5A5A_FFFC);
    tick();
    chk("wrap_next", if_pc, 32'h0);
    tick();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 2) != 0);
      tick();
    end
    drive(0, 0, 0, 1);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
